// File: rtl/defect_vote_filter.sv
// Majority-vote filter over the last WIN per-frame classifications, with a
// sticky acknowledged alarm for newly voted defect classes and sample counters.
module defect_vote_filter #(
    parameter int WIN   = 4,
    parameter int AGREE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        class_valid,
    input  logic [2:0]  classification,
    input  logic        flush,
    input  logic        alarm_ack,
    output logic [2:0]  voted_class,
    output logic        voted_valid,
    output logic        alarm,
    output logic [2:0]  alarm_class,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int         HW      = 3 * WIN;
    localparam logic [2:0] WIN_L   = 3'(WIN);
    localparam logic [2:0] AGREE_L = 3'(AGREE);

    logic [HW-1:0] hist_p0;
    logic [2:0]    fill_p0;
    logic          vld_p0;

    logic          accept;
    logic          bad_sample;
    logic [2:0]    cnt_p;
    logic [2:0]    cnt_s;
    logic [2:0]    cnt_n;
    logic          vote_hit;
    logic [2:0]    vote_cls;
    logic          do_vote;
    logic          alarm_evt;

    function automatic logic is_legal(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    function automatic logic [2:0] count_class(input logic [HW-1:0] h, input int b);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < WIN; i++)
            n = n + {2'b00, h[3*i+b]};
        return n;
    endfunction

    assign accept     = class_valid && !flush && is_legal(classification);
    assign bad_sample = class_valid && !flush && !is_legal(classification);

    assign cnt_p = count_class(hist_p0, 0);
    assign cnt_s = count_class(hist_p0, 1);
    assign cnt_n = count_class(hist_p0, 2);

    // Tie-break order is patches, scratches, nice.
    always_comb begin
        vote_hit = 1'b0;
        vote_cls = 3'b000;
        if (cnt_p >= AGREE_L) begin
            vote_hit = 1'b1;
            vote_cls = 3'b001;
        end else if (cnt_s >= AGREE_L) begin
            vote_hit = 1'b1;
            vote_cls = 3'b010;
        end else if (cnt_n >= AGREE_L) begin
            vote_hit = 1'b1;
            vote_cls = 3'b100;
        end
    end

    assign do_vote   = vld_p0 && (fill_p0 == WIN_L) && vote_hit && !flush;
    assign alarm_evt = do_vote && (vote_cls != 3'b100) &&
                       ((vote_cls != voted_class) || !voted_valid);

    // Stage p0: sample capture into history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_p0 <= '0;
            fill_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= accept;
            if (flush) begin
                hist_p0 <= '0;
                fill_p0 <= '0;
            end else if (accept) begin
                hist_p0 <= {hist_p0[HW-4:0], classification};
                if (fill_p0 != WIN_L)
                    fill_p0 <= fill_p0 + 3'd1;
            end
        end
    end

    // Stage p1: vote and alarm registered one edge after the sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            voted_class <= 3'b000;
            voted_valid <= 1'b0;
            alarm       <= 1'b0;
            alarm_class <= 3'b000;
        end else begin
            if (flush) begin
                voted_class <= 3'b000;
                voted_valid <= 1'b0;
            end else if (do_vote) begin
                voted_class <= vote_cls;
                voted_valid <= 1'b1;
            end
            if (alarm_evt) begin
                alarm       <= 1'b1;
                alarm_class <= vote_cls;
            end else if (alarm_ack) begin
                alarm <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (class_valid && (frame_cnt != 16'hFFFF))
                frame_cnt <= frame_cnt + 16'd1;
            if (bad_sample && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_defect_vote_filter.sv
// Directed bench for defect_vote_filter (WIN=4, AGREE=3): voting, alarm
// handshake, flush, invalid samples, counter saturation and async reset.
module tb_defect_vote_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        class_valid = 1'b0;
    logic [2:0]  classification = 3'b000;
    logic        flush = 1'b0;
    logic        alarm_ack = 1'b0;
    logic [2:0]  voted_class;
    logic        voted_valid;
    logic        alarm;
    logic [2:0]  alarm_class;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    defect_vote_filter #(.WIN(4), .AGREE(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .class_valid    (class_valid),
        .classification (classification),
        .flush          (flush),
        .alarm_ack      (alarm_ack),
        .voted_class    (voted_class),
        .voted_valid    (voted_valid),
        .alarm          (alarm),
        .alarm_class    (alarm_class),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic cv, input logic [2:0] cls, input logic fl, input logic ack);
        @(negedge clk);
        class_valid    = cv;
        classification = cls;
        flush          = fl;
        alarm_ack      = ack;
        @(posedge clk);
        #1;
        class_valid    = 1'b0;
        classification = 3'b000;
        flush          = 1'b0;
        alarm_ack      = 1'b0;
    endtask

    task automatic smp(input logic [2:0] cls);
        step(1'b1, cls, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_voted_class", voted_class, 3'b000);
        chk("rst_voted_valid", voted_valid, 1'b0);
        chk("rst_alarm", alarm, 1'b0);
        chk("rst_alarm_class", alarm_class, 3'b000);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill with 010,010,010,100: no vote until the history is full
        smp(3'b010);
        smp(3'b010);
        smp(3'b010);
        chk("fill3_valid", voted_valid, 1'b0);
        smp(3'b100);
        chk("fill4_valid_same_edge", voted_valid, 1'b0);
        idle();
        chk("vote1_class", voted_class, 3'b010);
        chk("vote1_valid", voted_valid, 1'b1);
        chk("vote1_alarm", alarm, 1'b1);
        chk("vote1_alarm_class", alarm_class, 3'b010);

        // 001,001 leaves no majority; third 001 switches the vote
        smp(3'b001);
        smp(3'b001);
        idle();
        chk("hold_class", voted_class, 3'b010);
        chk("hold_valid", voted_valid, 1'b1);
        smp(3'b001);
        idle();
        chk("vote2_class", voted_class, 3'b001);
        chk("vote2_alarm", alarm, 1'b1);
        chk("vote2_alarm_class", alarm_class, 3'b001);
        chk("frame_cnt_7", frame_cnt, 16'd7);

        // Ack lands on the same edge as a new alarm event
        smp(3'b010);
        smp(3'b010);
        smp(3'b010);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        chk("ack_evt_alarm", alarm, 1'b1);
        chk("ack_evt_alarm_class", alarm_class, 3'b010);
        chk("ack_evt_voted", voted_class, 3'b010);

        // Flush with a concurrent sample
        step(1'b1, 3'b001, 1'b1, 1'b0);
        chk("flush_voted_class", voted_class, 3'b000);
        chk("flush_voted_valid", voted_valid, 1'b0);
        chk("flush_alarm", alarm, 1'b1);
        chk("flush_alarm_class", alarm_class, 3'b010);
        chk("flush_frame_cnt", frame_cnt, 16'd11);
        chk("flush_err_cnt", err_cnt, 8'd0);

        smp(3'b001);
        smp(3'b001);
        smp(3'b001);
        idle();
        chk("refill3_valid", voted_valid, 1'b0);
        smp(3'b001);
        idle();
        chk("refill4_class", voted_class, 3'b001);
        chk("refill4_valid", voted_valid, 1'b1);
        chk("refill4_alarm_class", alarm_class, 3'b001);

        step(1'b0, 3'b000, 1'b0, 1'b1);
        chk("ack_clear_alarm", alarm, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1);
        chk("ack_idle_alarm", alarm, 1'b0);

        // Vote moving to nice never raises an alarm
        smp(3'b100);
        smp(3'b100);
        smp(3'b100);
        idle();
        chk("nice_class", voted_class, 3'b100);
        chk("nice_alarm", alarm, 1'b0);
        chk("nice_alarm_class", alarm_class, 3'b001);

        smp(3'b010);
        smp(3'b010);
        smp(3'b010);
        idle();
        chk("scratch_alarm", alarm, 1'b1);
        chk("scratch_alarm_class", alarm_class, 3'b010);
        smp(3'b100);
        smp(3'b100);
        smp(3'b100);
        idle();
        chk("nice2_class", voted_class, 3'b100);
        chk("nice2_alarm_persists", alarm, 1'b1);
        chk("nice2_alarm_class", alarm_class, 3'b010);
        chk("frame_cnt_24", frame_cnt, 16'd24);

        // Asynchronous reset while an alarm is pending
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_voted_class", voted_class, 3'b000);
        chk("arst_voted_valid", voted_valid, 1'b0);
        chk("arst_alarm", alarm, 1'b0);
        chk("arst_alarm_class", alarm_class, 3'b000);
        chk("arst_frame_cnt", frame_cnt, 16'd0);
        chk("arst_err_cnt", err_cnt, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Non-one-hot samples are counted but never enter the history
        smp(3'b000);
        smp(3'b011);
        smp(3'b111);
        chk("bad_err_cnt", err_cnt, 8'd3);
        chk("bad_frame_cnt", frame_cnt, 16'd3);
        chk("bad_voted_valid", voted_valid, 1'b0);
        smp(3'b001);
        smp(3'b001);
        smp(3'b001);
        idle();
        chk("post_rst_fill3_valid", voted_valid, 1'b0);
        smp(3'b001);
        idle();
        chk("post_rst_vote_class", voted_class, 3'b001);
        chk("post_rst_vote_valid", voted_valid, 1'b1);

        step(1'b1, 3'b011, 1'b1, 1'b0);
        chk("flush_bad_err_cnt", err_cnt, 8'd3);
        chk("flush_bad_frame_cnt", frame_cnt, 16'd8);

        for (int i = 0; i < 300; i++)
            smp(3'b110);
        chk("err_cnt_sat", err_cnt, 8'd255);
        chk("frame_cnt_308", frame_cnt, 16'd308);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/defect_vote_filter.md
DEFECT_VOTE_FILTER -- requirements
Module: defect_vote_filter

Interface
REQ-001 Parameter WIN, default 4, history depth in frames; legal range 2..7.
REQ-002 Parameter AGREE, default 3, minimum matching entries for a vote; legal range 1..WIN.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 class_valid  input  1  one-cycle strobe: classification holds a new per-frame result.
REQ-006 classification  input  3  per-frame result, one-hot: 001 patches, 010 scratches, 100 nice.
REQ-007 flush  input  1  synchronous clear of the vote history.
REQ-008 alarm_ack  input  1  acknowledges a pending alarm.
REQ-009 voted_class  output  3  filtered result, registered; 000 means undetermined.
REQ-010 voted_valid  output  1  high when voted_class holds a decided vote.
REQ-011 alarm  output  1  level; defect decision pending acknowledge.
REQ-012 alarm_class  output  3  class that raised the current alarm.
REQ-013 frame_cnt  output  16  count of class_valid strobes, saturating.
REQ-014 err_cnt  output  8  count of non-one-hot samples, saturating.

Function
REQ-015 History: WIN-entry shift register of 3-bit results plus a fill counter 0..WIN.
REQ-016 Sample accepted: class_valid=1, flush=0, and classification in {001,010,100}.
  - Shifts into history at that edge.
  - Fill counter increments, saturating at WIN.
REQ-017 Invalid sample: class_valid=1 with any other code (including 000).
  - History and fill counter unchanged.
  - err_cnt increments, saturating at 255.
REQ-018 Every class_valid edge increments frame_cnt (saturating at 65535), regardless of validity or flush.
REQ-019 Vote state FILL while fill counter < WIN.
  - voted_valid=0 and voted_class unchanged.
REQ-020 Vote state RUN when fill counter = WIN.
  - Per-class counts over the full history, computed combinationally from the updated history.
REQ-021 Vote latency: edge E accepts a sample; edge E+1 registers voted_class, voted_valid and alarm.
REQ-022 Vote rule when any class count >= AGREE:
  - That class becomes voted_class and voted_valid=1.
  - Ties resolve by priority: patches, then scratches, then nice.
REQ-023 When no class count reaches AGREE, voted_class and voted_valid hold their previous values.
REQ-024 Alarm event at edge E+1 when both hold:
  - The new voted_class is 001 or 010.
  - It differs from the previous voted_class, or the previous voted_valid was 0.
REQ-025 An alarm event sets alarm=1 and alarm_class to the new voted_class.
REQ-026 alarm clears on the first edge with alarm_ack=1 and no simultaneous alarm event.
REQ-027 Ack coinciding with an alarm event: alarm stays 1 and alarm_class takes the new class.
REQ-028 Ack while alarm=0 is ignored.
REQ-029 A repeat alarm event while alarm=1 updates alarm_class only.
REQ-030 flush at an edge:
  - Clears fill counter and history to 000, voted_class to 000 and voted_valid to 0.
  - A simultaneous class_valid sample is discarded from history and err_cnt.
  - alarm, alarm_class and frame_cnt are unaffected by flush itself.
REQ-031 A transition to nice (100) never raises an alarm; an existing alarm persists until acked.

Reset
REQ-032 rst=1 asynchronously forces:
  - history=000, fill=0;
  - voted_class=000, voted_valid=0;
  - alarm=0, alarm_class=000;
  - frame_cnt=0, err_cnt=0.
REQ-033 Assertion of rst mid-frame or mid-alarm discards all state.
  - First legal sample after release starts at fill=1.

Verification
REQ-034 Samples 010,010,010,100 (WIN=4, AGREE=3) -> voted_valid=0 after samples 1-3; one edge after sample 4, voted_class=010, voted_valid=1, alarm=1, alarm_class=010.
REQ-035 Continue from REQ-034 with 001,001 -> history 010,100,001,001 has no count >= 3, so voted_class stays 010; one more 001 -> voted_class=001, alarm_class=001, alarm stays 1.
REQ-036 alarm_ack on the same edge as an alarm event -> alarm=1 with the new class; a later ack alone -> alarm=0 next edge.
REQ-037 Samples 000, 011 and 111 -> err_cnt=3, frame_cnt=3, fill=0, voted_valid=0; err_cnt holds 255 after 300 invalid samples.
REQ-038 flush together with class_valid(001) after a vote -> voted_class=000, voted_valid=0, fill=0, frame_cnt+1, alarm unchanged; rst pulse mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
